branch_target_buffer: RTL and testbench

IF-stage branch predictor that produces the `BranchPredictedD` bit and predicted next PC consumed downstream by the ID-EX segment register. It also closes the loop from EX: it takes the resolved branch outcome, detects mispredictions, issues the redirect PC, and trains its table. The table is direct-mapped, one entry per index, with a valid bit, full tag, target and 2-bit saturating counter per entry. The block also keeps saturating branch and mispredict statistics counters.

---
 rtl/btb_pkg.sv | 13 +
 rtl/branch_target_buffer_if.sv | 23 ++
 rtl/btb_table.sv | 48 ++++
 rtl/branch_target_buffer.sv | 43 ++++
 tb/tb_branch_target_buffer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared sizing, counter encodings and PC field extraction for the branch target buffer
package btb_pkg;
  localparam int ENTRIES = 64;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    return pc[31:IDX_W+2];
  endfunction
endpackage

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: fetch lookup, EX resolve and statistics signals of the branch target buffer
interface branch_target_buffer_if;
  logic [31:0] PCF;
  logic PredictedF;
  logic [31:0] PredictedNPCF;
  logic BranchE;
  logic [31:0] PCE;
  logic [31:0] BrTargetE;
  logic BrTakenE;
  logic BranchPredictedE;
  logic MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MissCnt;
  modport master (
    output PCF, BranchE, PCE, BrTargetE, BrTakenE, BranchPredictedE,
    input PredictedF, PredictedNPCF, MispredictE, RedirectPCE, BranchCnt, MissCnt
  );
  modport slave (
    input PCF, BranchE, PCE, BrTargetE, BrTakenE, BranchPredictedE,
    output PredictedF, PredictedNPCF, MispredictE, RedirectPCE, BranchCnt, MissCnt
  );
endinterface

// File: rtl/btb_table.sv
// btb_table: direct-mapped entry storage with an async fetch read port and an EX read-modify-write port
module btb_table
  import btb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] f_idx,
  output logic             f_valid,
  output logic [TAG_W-1:0] f_tag,
  output logic [31:0]      f_target,
  output ctr_t             f_ctr,
  input  logic [IDX_W-1:0] e_idx,
  output logic             e_valid,
  output logic [TAG_W-1:0] e_tag,
  output logic [31:0]      e_target,
  output ctr_t             e_ctr,
  input  logic             we,
  input  logic [TAG_W-1:0] w_tag,
  input  logic [31:0]      w_target,
  input  ctr_t             w_ctr
);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [31:0] target [ENTRIES];
  ctr_t ctr [ENTRIES];
  assign f_valid = valid[f_idx];
  assign f_tag = tag[f_idx];
  assign f_target = target[f_idx];
  assign f_ctr = ctr[f_idx];
  assign e_valid = valid[e_idx];
  assign e_tag = tag[e_idx];
  assign e_target = target[e_idx];
  assign e_ctr = ctr[e_idx];
  always_ff @(posedge clk)
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        target[i] <= '0;
        ctr[i] <= WNT;
      end
    end else if (we) begin
      valid[e_idx] <= 1'b1;
      tag[e_idx] <= w_tag;
      target[e_idx] <= w_target;
      ctr[e_idx] <= w_ctr;
    end
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: IF-stage taken/target prediction, EX mispredict redirect, table training and statistics
module branch_target_buffer
  import btb_pkg::*;
(
  input logic clk,
  input logic rst,
  branch_target_buffer_if.slave bus
);
  logic f_valid, e_valid, f_hit, e_hit, we;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic [31:0] f_target, e_target, w_target, bcnt, mcnt;
  ctr_t f_ctr, e_ctr, w_ctr;
  btb_table u_table (
    .clk(clk), .rst(rst),
    .f_idx(idx_of(bus.PCF)), .f_valid(f_valid), .f_tag(f_tag), .f_target(f_target), .f_ctr(f_ctr),
    .e_idx(idx_of(bus.PCE)), .e_valid(e_valid), .e_tag(e_tag), .e_target(e_target), .e_ctr(e_ctr),
    .we(we), .w_tag(tag_of(bus.PCE)), .w_target(w_target), .w_ctr(w_ctr)
  );
  always_comb begin
    f_hit = f_valid && f_tag == tag_of(bus.PCF);
    e_hit = e_valid && e_tag == tag_of(bus.PCE);
    bus.PredictedF = f_hit && f_ctr[1];
    bus.PredictedNPCF = bus.PredictedF ? f_target : bus.PCF + 32'd4;
    bus.MispredictE = bus.BranchE && (bus.BranchPredictedE != bus.BrTakenE);
    bus.RedirectPCE = bus.BrTakenE ? bus.BrTargetE : bus.PCE + 32'd4;
    // a not-taken miss leaves the table alone; everything else writes the indexed entry
    we = bus.BranchE && (e_hit || bus.BrTakenE);
    w_target = bus.BrTakenE ? bus.BrTargetE : e_target;
    w_ctr = !e_hit ? WT
          : bus.BrTakenE ? (e_ctr == ST ? ST : ctr_t'(e_ctr + 2'd1))
          : (e_ctr == SNT ? SNT : ctr_t'(e_ctr - 2'd1));
  end
  always_ff @(posedge clk)
    if (rst) begin
      bcnt <= '0;
      mcnt <= '0;
    end else if (bus.BranchE) begin
      bcnt <= bcnt + {31'd0, ~&bcnt};
      mcnt <= mcnt + {31'd0, bus.MispredictE && ~&mcnt};
    end
  assign bus.BranchCnt = bcnt;
  assign bus.MissCnt = mcnt;
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: random and directed scoreboard check of the branch target buffer against a table model
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  branch_target_buffer_if bus ();
  branch_target_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit chk;
    bit pred;
    logic [31:0] npc;
    bit mis;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;
  exp_t q[$];
  event issued;
  int n_chk = 0;
  int n_fail = 0;

  bit m_valid [64];
  logic [31:0] m_pc [64];
  logic [31:0] m_tgt [64];
  int m_ctr [64];
  logic [31:0] m_bc, m_mc;
  bit m_known = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction
  function automatic bit hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_pc[slot(pc)] / 256) == (pc / 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [31:0] pcf, input bit be, input logic [31:0] pce,
                      input logic [31:0] tgt, input bit taken, input bit pred, input bit r);
    exp_t e;
    int s;
    @(negedge clk);
    rst = r;
    bus.PCF = pcf;
    bus.BranchE = be;
    bus.PCE = pce;
    bus.BrTargetE = tgt;
    bus.BrTakenE = taken;
    bus.BranchPredictedE = pred;
    e.chk = m_known;
    e.pred = hit(pcf) && m_ctr[slot(pcf)] >= 2;
    e.npc = e.pred ? m_tgt[slot(pcf)] : pcf + 32'd4;
    e.mis = be && (pred != taken);
    e.redir = taken ? tgt : pce + 32'd4;
    e.bc = m_bc;
    e.mc = m_mc;
    q.push_back(e);
    ->issued;
    if (r) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 0;
        m_pc[i] = 0;
        m_tgt[i] = 0;
        m_ctr[i] = 1;
      end
      m_bc = 0;
      m_mc = 0;
      m_known = 1;
    end else if (be) begin
      s = slot(pce);
      if (m_bc != 32'hFFFF_FFFF) m_bc++;
      if (e.mis && m_mc != 32'hFFFF_FFFF) m_mc++;
      if (hit(pce)) begin
        if (taken) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = tgt;
        end else m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end else if (taken) begin
        m_valid[s] = 1;
        m_pc[s] = pce;
        m_tgt[s] = tgt;
        m_ctr[s] = 2;
      end
    end
  endtask

  task automatic look(input logic [31:0] pcf);
    step(pcf, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask
  task automatic resolve(input logic [31:0] pcf, input logic [31:0] pce, input logic [31:0] tgt,
                         input bit taken, input bit pred);
    step(pcf, 1, pce, tgt, taken, pred, 0);
  endtask

  initial
    forever begin
      exp_t e;
      @(issued);
      #1;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        e = q.pop_front();
        if (e.chk) begin
          check("PredictedF", {31'd0, bus.PredictedF}, {31'd0, e.pred});
          check("PredictedNPCF", bus.PredictedNPCF, e.npc);
          check("MispredictE", {31'd0, bus.MispredictE}, {31'd0, e.mis});
          if (e.mis) check("RedirectPCE", bus.RedirectPCE, e.redir);
          check("BranchCnt", bus.BranchCnt, e.bc);
          check("MissCnt", bus.MissCnt, e.mc);
        end
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pce;
    bit tk;
    rst = 1'b1;
    bus.PCF = 0;
    bus.BranchE = 0;
    bus.PCE = 0;
    bus.BrTargetE = 0;
    bus.BrTakenE = 0;
    bus.BranchPredictedE = 0;
    step(32'h40, 0, 0, 0, 0, 0, 1);
    step(32'h40, 0, 0, 0, 0, 0, 1);
    look(32'h40);
    // allocation while fetching the same PC: prediction flips only on the following cycle
    resolve(32'h40, 32'h40, 32'h100, 1, 0);
    look(32'h40);
    resolve(32'h40, 32'h40, 32'h100, 0, 1);
    resolve(32'h40, 32'h40, 32'h100, 0, 0);
    resolve(32'h40, 32'h40, 32'h100, 0, 0);
    resolve(32'h40, 32'h40, 32'h100, 0, 0);
    look(32'h40);
    resolve(32'h40, 32'h40, 32'h100, 1, 0);
    resolve(32'h40, 32'h40, 32'h100, 1, 0);
    look(32'h40);
    resolve(32'h140, 32'h140, 32'h200, 1, 0);
    look(32'h40);
    look(32'h140);
    look(32'h140);
    @(negedge clk);
    force dut.bcnt = 32'hFFFF_FFFE;
    force dut.mcnt = 32'hFFFF_FFFE;
    #1;
    release dut.bcnt;
    release dut.mcnt;
    m_bc = 32'hFFFF_FFFE;
    m_mc = 32'hFFFF_FFFE;
    look(32'h140);
    resolve(32'h140, 32'h80, 32'h300, 1, 0);
    resolve(32'h140, 32'h84, 32'h304, 1, 0);
    resolve(32'h140, 32'h88, 32'h308, 0, 1);
    look(32'h80);
    step(32'h80, 1, 32'h90, 32'h400, 1, 0, 1);
    look(32'h80);
    look(32'h140);
    look(32'h90);
    repeat (600) begin
      pce = {22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
      tk = 1'($urandom);
      step({22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00},
           $urandom_range(0, 3) != 0, pce, 32'($urandom) & 32'hFFFF_FFFC, tk,
           ($urandom_range(0, 3) == 0) ? ~tk : (hit(pce) && m_ctr[slot(pce)] >= 2),
           $urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
